fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
// Sequences the combinational instruction memory: owns the fetch PC, drives imem_addr,
// buffers fetched {pc, instr, exception} entries in an in-order queue, and hands them to
// decode over a valid/ready handshake. Handles control-flow redirects (branch/jump/trap)
// and parks fetch after an instruction access fault until redirected.
// PARAMETERS
// RESET_PC    64'h0  PC fetched first after reset
// QUEUE_DEPTH 2      fetch queue entries (power of 2, >=2)
// PORTS
// clk            in   1   clock, all state on rising edge
// rst            in   1   synchronous, active-high reset
// imem_addr      out  64  fetch address to imem (= PC register)
// imem_instr     in   32  instruction word from imem (combinational, same cycle)
// imem_exc_en    in   1   imem access fault for imem_addr
// imem_exc_code  in   4   imem exception cause
// imem_exc_val   in   64  imem exception value (faulting PC)
// redirect_en    in   1   flush queue and restart fetch at redirect_pc
// redirect_pc    in   64  new fetch PC
// out_valid      out  1   head entry valid
// out_ready      in   1   decode accepts head entry
// out_pc         out  64  PC of head entry
// out_instr      out  32  instruction of head entry; 32'h00000013 when queue empty
// out_exc_en     out  1   head entry carries an exception
// out_exc_code   out  4   exception cause of head entry
// out_exc_val    out  64  exception value of head entry
// fetch_halted   out  1   FSM in HALT
// BEHAVIOUR
// - Reset: pc=RESET_PC, queue empty, FSM=RUN; out_valid=0, out_instr=32'h13, out_pc=0,
//   out_exc_en=0, out_exc_code=0, out_exc_val=0, fetch_halted=0. Reset overrides all inputs.
// - imem_addr = pc register (no combinational path from redirect_pc).
// - pop = out_valid & out_ready & ~redirect_en. push allowed when FSM=RUN and
//   (count<QUEUE_DEPTH or pop). Push and pop in same cycle when full: legal, count unchanged.
// - Push writes {pc, imem_instr, imem_exc_en, imem_exc_code, imem_exc_val} to tail.
//   On push with imem_exc_en=0: pc<=pc+4 (64-bit wrap). No push: pc holds.
// - Push with imem_exc_en=1: entry stored with instr=32'h13, pc holds, FSM RUN->HALT.
//   Entry is delivered in order behind older entries; exactly one fault entry per fault.
// - HALT: no pushes, pc holds, queue still drains. Leaves only via redirect or rst.
// - redirect_en (any FSM state, wins over push/pop that cycle): queue flushed (count=0,
//   head entry not consumed), FSM=RUN. If redirect_pc[1:0]==0: pc<=redirect_pc, first new
//   entry pushed next cycle. Else: pc<=redirect_pc, one entry pushed next cycle with
//   exc_en=1, exc_code=0 (instr addr misaligned), exc_val=redirect_pc, instr=32'h13,
//   and FSM->HALT; imem result ignored for that entry. redirect_pc[1]=1 is treated as misaligned (no C extension).
// - Latency: redirect to out_valid = 2 cycles (queue registered); steady state 1 instr/cycle.
// - Queue outputs are registered from storage; out_* stable while out_valid & ~out_ready.
// - Back-to-back redirects: last one wins; no entries from earlier target appear.
// TESTING
// 1 Reset released, out_ready=1, imem holds seq -> out_pc 0,4,8,.. one per cycle after
//   first, out_instr matches imem, out_exc_en=0.
// 2 out_ready=0 for 5 cycles -> exactly QUEUE_DEPTH entries held, imem_addr frozen at
//   8 (DEPTH=2), resume -> pc 0,4,8 delivered, none dropped or duplicated.
// 3 Sequential fetch reaches 0x2000 (imem faults, exc_val=0x2000) -> one entry with
//   out_exc_en=1, exc_code=1, exc_val=0x2000, instr 0x13; fetch_halted=1; no further entries.
// 4 redirect_en, redirect_pc=0x100 while queue full and out_ready=1 -> head not consumed,
//   queue flushed, two cycles later out_pc=0x100; fetch_halted cleared.
// 5 redirect_pc=0x102 -> single entry exc_en=1, exc_code=0, exc_val=0x102, then halted.
// 6 rst asserted mid-stream with entries queued -> next cycle out_valid=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the fetch PC, fetches from a combinational imem, buffers
// {pc, instr, exception} entries in an in-order queue and hands them to decode.
// Redirects flush the queue and restart fetch; a fetch fault parks the fetcher.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc_en,
  output logic [3:0]  out_exc_code,
  output logic [63:0] out_exc_val,
  output logic        fetch_halted
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam logic [3:0]  EXC_MISALIGNED = 4'd0;
  localparam logic [63:0] PC_STEP        = 64'd4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } entry_t;

  // ST_MISALIGN: a misaligned redirect target still owes its single fault entry
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MISALIGN = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  entry_t           mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push, pop, full, room;
  entry_t           push_entry;
  entry_t           head;

  assign imem_addr = pc_q;
  assign out_valid = (count_q != CNT_W'(0));
  assign full      = (count_q == CNT_W'(QUEUE_DEPTH));
  assign pop       = out_valid & out_ready & ~redirect_en;
  assign room      = ~full | pop;
  assign fetch_halted = (state_q == ST_HALT);

  // FSM state and fetch PC registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state, next PC and the entry pushed this cycle
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    push       = 1'b0;
    push_entry = '{pc:       pc_q,
                   instr:    imem_instr,
                   exc_en:   imem_exc_en,
                   exc_code: imem_exc_code,
                   exc_val:  imem_exc_val};
    if (redirect_en) begin
      pc_d    = redirect_pc;
      state_d = (redirect_pc[1:0] == 2'b00) ? ST_RUN : ST_MISALIGN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (room) begin
            push = 1'b1;
            if (imem_exc_en) begin
              push_entry.instr = NOP_INSTR;
              state_d          = ST_HALT;
            end else begin
              pc_d = pc_q + PC_STEP;
            end
          end
        end
        ST_MISALIGN: begin
          if (room) begin
            push       = 1'b1;
            push_entry = '{pc:       pc_q,
                           instr:    NOP_INSTR,
                           exc_en:   1'b1,
                           exc_code: EXC_MISALIGNED,
                           exc_val:  pc_q};
            state_d    = ST_HALT;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Queue pointers and occupancy; a redirect flushes without consuming the head
  always_ff @(posedge clk) begin
    if (rst || redirect_en) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Queue storage; contents are only observed while counted as valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  // Head entry presented from storage; idle values when the queue is empty
  always_comb begin
    head         = mem_q[rd_ptr_q];
    out_pc       = 64'h0;
    out_instr    = NOP_INSTR;
    out_exc_en   = 1'b0;
    out_exc_code = 4'h0;
    out_exc_val  = 64'h0;
    if (out_valid) begin
      out_pc       = head.pc;
      out_instr    = head.instr;
      out_exc_en   = head.exc_en;
      out_exc_code = head.exc_code;
      out_exc_val  = head.exc_val;
    end
  end

endmodule
